// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// fifo_arb_pkg : shared state encoding and index helpers for fifo_enq_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    // Explicit modulo-n increment; n need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_enq_arbiter_if.sv
// ============================================================================
// fifo_enq_arbiter_if : requester streams plus the single FIFO enqueue stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_enq_arbiter_if #(
    parameter int  N_REQ    = 4,
    parameter type PACKET_T = logic [31:0]
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    PACKET_T          req_packet [N_REQ];
    logic             out_valid;
    logic             out_ready;
    PACKET_T          packet_out;
    logic [IDW-1:0]   grant_id;
    logic             burst_active;

    modport master (
        input  req_valid, req_packet, out_ready,
        output req_ready, out_valid, packet_out, grant_id, burst_active
    );

    modport slave (
        output req_valid, req_packet, out_ready,
        input  req_ready, out_valid, packet_out, grant_id, burst_active
    );

endinterface

`default_nettype wire

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational rotating-priority picker, first set bit from start
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_mask,
    input  logic [IDW-1:0]   start,
    output logic             found,
    output logic [IDW-1:0]   idx
);

    int w_pos;

    // Walk positions in priority order; constant indices keep the mux tree static.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = int'(start) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && (w_pos == j) && req_mask[j]) begin
                    found = 1'b1;
                    idx   = IDW'(j);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_enq_arbiter.sv
// ============================================================================
// fifo_enq_arbiter : N producers onto one FIFO enqueue port, rotating priority
// with burst lock; zero-latency combinational grant.
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_enq_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  MAX_BURST = 4,
    parameter type PACKET_T  = logic [31:0]
) (
    input  logic               clock,
    input  logic               reset,
    fifo_enq_arbiter_if.master bus
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_burst_len = CNT_W'(MAX_BURST);

    arb_state_e       r_state;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_release;
    logic [IDW-1:0]   w_owner_inc;
    logic [IDW-1:0]   w_start;
    logic             w_pick_found;
    logic [IDW-1:0]   w_pick_idx;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_grant_inc;
    logic             w_valid;
    logic             w_out_valid;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_inc;
    PACKET_T          w_packet;

    assign w_owner_inc = IDW'(wrap_inc(int'(r_owner), N_REQ));
    assign w_grant_inc = IDW'(wrap_inc(int'(w_grant), N_REQ));

    // Owner dropped valid mid-burst: arbitrate now with the old owner last.
    assign w_release = (r_state == BURST) && !bus.req_valid[r_owner];
    assign w_start   = w_release ? w_owner_inc : r_rr_ptr;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_mask (bus.req_valid),
        .start    (w_start),
        .found    (w_pick_found),
        .idx      (w_pick_idx)
    );

    always_comb begin
        w_grant = w_pick_idx;
        w_valid = w_pick_found;
        if ((r_state == WAIT) || ((r_state == BURST) && !w_release)) begin
            w_grant = r_owner;
            w_valid = 1'b1;
        end
    end

    assign w_out_valid = w_valid && !reset;
    assign w_accept    = w_out_valid && bus.out_ready;

    // A new grantee after release starts its own burst count from scratch.
    assign w_cnt_base  = w_release ? '0 : r_beat_cnt;
    assign w_cnt_inc   = w_cnt_base + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (w_out_valid && !bus.out_ready) begin
            r_state <= WAIT;
            r_owner <= w_grant;
        end else if (w_accept) begin
            if (w_cnt_inc == c_burst_len) begin
                r_state    <= IDLE;
                r_beat_cnt <= '0;
                r_rr_ptr   <= w_grant_inc;
            end else begin
                r_state    <= BURST;
                r_owner    <= w_grant;
                r_beat_cnt <= w_cnt_inc;
            end
        end else if (w_release) begin
            r_state    <= IDLE;
            r_rr_ptr   <= w_owner_inc;
            r_beat_cnt <= '0;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = w_accept && (w_grant == IDW'(gi));
    end

    assign w_packet         = bus.req_packet[w_grant];
    assign bus.packet_out   = w_packet;
    assign bus.out_valid    = w_out_valid;
    assign bus.grant_id     = w_grant;
    assign bus.burst_active = (r_state == BURST) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_fifo_enq_arbiter.sv
// ============================================================================
// tb_fifo_enq_arbiter : directed checks of grant order, burst lock, WAIT, reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_enq_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_enq_arbiter_if #(.N_REQ(4), .PACKET_T(logic [31:0])) ia ();
    fifo_enq_arbiter_if #(.N_REQ(4), .PACKET_T(logic [31:0])) ib ();
    fifo_enq_arbiter_if #(.N_REQ(3), .PACKET_T(logic [31:0])) ic ();

    fifo_enq_arbiter #(.N_REQ(4), .MAX_BURST(4), .PACKET_T(logic [31:0])) dut_a (
        .clock (clk), .reset (rst), .bus (ia.master)
    );
    fifo_enq_arbiter #(.N_REQ(4), .MAX_BURST(1), .PACKET_T(logic [31:0])) dut_b (
        .clock (clk), .reset (rst), .bus (ib.master)
    );
    fifo_enq_arbiter #(.N_REQ(3), .MAX_BURST(1), .PACKET_T(logic [31:0])) dut_c (
        .clock (clk), .reset (rst), .bus (ic.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ia.req_valid = '0; ia.out_ready = 1'b0;
        ib.req_valid = '0; ib.out_ready = 1'b0;
        ic.req_valid = '0; ic.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ia.req_packet[i] = 32'hA0 + i;
            ib.req_packet[i] = 32'hB0 + i;
        end
        for (int i = 0; i < 3; i++) begin
            ic.req_packet[i] = 32'hC0 + i;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        logic [2:0] exp_rdy3;
        int         g;

        // Reset state
        clear_inputs();
        tick();
        #1;
        chk("rst out_valid", 32'(ia.out_valid), 32'd0);
        chk("rst req_ready", 32'(ia.req_ready), 32'd0);
        chk("rst burst_active", 32'(ia.burst_active), 32'd0);
        chk("rst grant_id", 32'(ia.grant_id), 32'd0);
        rst = 1'b0;

        // All four valid, MAX_BURST=4: 0,0,0,0,1,1,1,1,...,3,3,3,3,0
        ia.req_valid = 4'hF;
        ia.out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            #1;
            g       = (c / 4) % 4;
            exp_rdy = 4'(1 << g);
            chk($sformatf("burst grant c%0d", c), 32'(ia.grant_id), 32'(g));
            chk($sformatf("burst ready c%0d", c), 32'(ia.req_ready), 32'(exp_rdy));
            chk($sformatf("burst packet c%0d", c), ia.packet_out, 32'hA0 + g);
            chk($sformatf("burst active c%0d", c), 32'(ia.burst_active), 32'((c % 4) != 0));
            tick();
        end

        // Release: requester 1 drops after 2 beats, 3 takes over with no bubble
        apply_reset();
        ia.req_valid = 4'b1010;
        ia.out_ready = 1'b1;
        #1;
        chk("rel c0 grant", 32'(ia.grant_id), 32'd1);
        chk("rel c0 active", 32'(ia.burst_active), 32'd0);
        tick();
        #1;
        chk("rel c1 grant", 32'(ia.grant_id), 32'd1);
        chk("rel c1 active", 32'(ia.burst_active), 32'd1);
        tick();
        ia.req_valid = 4'b1000;
        #1;
        chk("rel c2 grant", 32'(ia.grant_id), 32'd3);
        chk("rel c2 out_valid", 32'(ia.out_valid), 32'd1);
        chk("rel c2 ready", 32'(ia.req_ready), 32'b1000);
        chk("rel c2 packet", ia.packet_out, 32'hA3);
        tick();
        for (int c = 3; c < 6; c++) begin
            #1;
            chk($sformatf("rel c%0d grant", c), 32'(ia.grant_id), 32'd3);
            chk($sformatf("rel c%0d active", c), 32'(ia.burst_active), 32'd1);
            tick();
        end
        ia.req_valid = 4'b1010;
        #1;
        chk("rel c6 grant", 32'(ia.grant_id), 32'd1);
        chk("rel c6 active", 32'(ia.burst_active), 32'd0);

        // Requester 2 held in WAIT by a full FIFO while requester 0 appears
        apply_reset();
        ia.req_valid = 4'b0100;
        ia.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("wait c%0d grant", c), 32'(ia.grant_id), 32'd2);
            chk($sformatf("wait c%0d out_valid", c), 32'(ia.out_valid), 32'd1);
            chk($sformatf("wait c%0d ready", c), 32'(ia.req_ready), 32'd0);
            chk($sformatf("wait c%0d packet", c), ia.packet_out, 32'hA2);
            tick();
            ia.req_valid = 4'b0101;
        end
        ia.out_ready = 1'b1;
        #1;
        chk("wait accept grant", 32'(ia.grant_id), 32'd2);
        chk("wait accept ready", 32'(ia.req_ready), 32'b0100);
        tick();
        ia.req_valid = 4'b0001;
        #1;
        chk("wait after grant", 32'(ia.grant_id), 32'd0);
        chk("wait after ready", 32'(ia.req_ready), 32'b0001);
        chk("wait after active", 32'(ia.burst_active), 32'd1);

        // Reset while in WAIT owned by requester 2
        apply_reset();
        ia.req_valid = 4'b0100;
        ia.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        ia.req_valid = 4'b0101;
        #1;
        chk("rstwait during out_valid", 32'(ia.out_valid), 32'd0);
        chk("rstwait during ready", 32'(ia.req_ready), 32'd0);
        chk("rstwait during active", 32'(ia.burst_active), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstwait after grant", 32'(ia.grant_id), 32'd0);
        chk("rstwait after out_valid", 32'(ia.out_valid), 32'd1);
        chk("rstwait after active", 32'(ia.burst_active), 32'd0);

        // MAX_BURST=1, requesters 1 and 3: strict alternation
        apply_reset();
        ib.req_valid = 4'b1010;
        ib.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            g       = (c % 2 == 0) ? 1 : 3;
            exp_rdy = 4'(1 << g);
            chk($sformatf("rr1 grant c%0d", c), 32'(ib.grant_id), 32'(g));
            chk($sformatf("rr1 ready c%0d", c), 32'(ib.req_ready), 32'(exp_rdy));
            chk($sformatf("rr1 packet c%0d", c), ib.packet_out, 32'hB0 + g);
            chk($sformatf("rr1 active c%0d", c), 32'(ib.burst_active), 32'd0);
            tick();
        end

        // N_REQ=3, MAX_BURST=1, all valid: 0,1,2,0,1,2
        apply_reset();
        ic.req_valid = 3'b111;
        ic.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            g        = c % 3;
            exp_rdy3 = 3'(1 << g);
            chk($sformatf("n3 grant c%0d", c), 32'(ic.grant_id), 32'(g));
            chk($sformatf("n3 ready c%0d", c), 32'(ic.req_ready), 32'(exp_rdy3));
            chk($sformatf("n3 packet c%0d", c), ic.packet_out, 32'hC0 + g);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Shares one FIFO enqueue port between `N_REQ` producers. Each producer presents its own valid/ready/packet stream. The block grants one producer at a time using rotating priority, with an optional burst lock, and drives a single valid/ready/packet stream into the FIFO's `in_valid`/`in_ready`/`packet_in`. The grant decision is combinational, so the block adds no latency and no bubbles on the datapath.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥2 and need not be a power of two.
- `MAX_BURST`, default 4: maximum consecutive accepted beats per grant; must be ≥1. A value of 1 gives pure round-robin.
- `PACKET_T`, default `logic [31:0]`: payload type, identical to the FIFO's.
- `IDW`, derived as `$clog2(N_REQ)`: requester index width.
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `N_REQ`: per-requester valid.
- `req_ready`, out, `N_REQ`: per-requester accept; at most one bit is high in any cycle.
- `req_packet`, in, `N_REQ` x `PACKET_T`: per-requester payload.
- `out_valid`, out, 1: drives FIFO `in_valid`.
- `out_ready`, in, 1: driven by FIFO `in_ready`.
- `packet_out`, out, `PACKET_T`: drives FIFO `packet_in`; equals `req_packet[grant_id]`.
- `grant_id`, out, `IDW`: current grantee; meaningful only while `out_valid`=1.
- `burst_active`, out, 1: high when the state is BURST.

## Operation
- Producer protocol: once `req_valid[i]` is asserted, it stays high with a stable packet until `req_ready[i]` is seen. The arbiter relies on this rule.
- Registered state:
  - `state` ∈ {IDLE, WAIT, BURST}.
  - `owner`, width `IDW`.
  - `rr_ptr`, width `IDW`: highest-priority index for the next arbitration.
  - `beat_cnt`, width `$clog2(MAX_BURST+1)`.
- Arbitration (pick): the first `i` with `req_valid[i]`=1, searching `rr_ptr`, `rr_ptr+1`, …, with indices wrapping modulo `N_REQ`.
- Per-state grant:
  - IDLE: `grant_id` = pick; `out_valid` = OR of `req_valid`.
  - WAIT: `grant_id` = `owner` unconditionally; `out_valid`=1. The stream must not change while not accepted.
  - BURST with `req_valid[owner]`=1: `grant_id` = `owner`; `out_valid`=1.
  - BURST with `req_valid[owner]`=0 (release): behaves exactly as IDLE in the same cycle, but with `rr_ptr` taken as `owner+1` (wrapped). Other requesters are served with no bubble, and the former owner has lowest priority.
- Handshake: `req_ready[i]` = `out_valid` && `out_ready` && (`grant_id`==`i`). Accept = `out_valid` && `out_ready`.
- Next state, evaluated in priority order:
  1. `out_valid`=1 and not accepted → WAIT; `owner` ← `grant_id`; `beat_cnt` unchanged.
  2. Accept with `beat_cnt+1` == `MAX_BURST` → IDLE; `beat_cnt` ← 0; `rr_ptr` ← `grant_id+1` (wrapped).
  3. Accept otherwise → BURST; `owner` ← `grant_id`; `beat_cnt` ← `beat_cnt+1`. If `grant_id` differs from the previous owner (release case), `beat_cnt` ← 1 instead.
  4. `out_valid`=0 in BURST-release → IDLE; `rr_ptr` ← `owner+1`; `beat_cnt` ← 0.
  5. `out_valid`=0 in IDLE → hold all state.
- Wrap arithmetic is explicit (`N_REQ-1` → 0); do not rely on power-of-two overflow.
- `beat_cnt` never exceeds `MAX_BURST-1` in a registered state.

## Timing
- Zero-cycle latency, requester to FIFO: `out_valid` and `packet_out` are combinational from `req_valid`, `req_packet` and state.
- `req_ready` is combinational from `out_ready`. There is no combinational path from `out_ready` to `out_valid` or `grant_id`.
- Sustained throughput: 1 beat per cycle while any requester is valid and `out_ready`=1, including across grant changes.
- Reset values:
  - State: IDLE; `owner`=0; `rr_ptr`=0; `beat_cnt`=0.
  - Outputs during reset: `burst_active`=0; `req_ready`=0; `out_valid`=0.
  - After reset: `grant_id`=0 while nothing is valid.
- Reset asserted mid-burst or in WAIT abandons the grant. The first post-reset arbitration starts at index 0.
- A full FIFO (`out_ready`=0) holds the grant in WAIT indefinitely. No rotation occurs until acceptance.

## Structure
- Package `fifo_arb_pkg` holds:
  - `arb_state_e` enum (IDLE, WAIT, BURST).
  - A function `wrap_inc(idx, n)` shared by the `rr_ptr` and `owner` updates.
- One sub-module, `rr_pick`: a combinational rotating-priority picker. Parameters: `N_REQ`. Inputs: `req_mask` and start pointer. Outputs: `found` and `idx`. It is instantiated once; the BURST-release case only changes the pointer fed to it.
- The FIFO itself is instantiated at the level above, not inside this block.

## Test plan
- All four requesters valid continuously, `MAX_BURST`=4, `out_ready`=1:
  - Grants run 0,0,0,0,1,1,1,1,2…; 16 beats in 16 cycles.
  - `rr_ptr` wraps 3 → 0.
- `MAX_BURST`=1, requesters 1 and 3 valid: grants alternate 1,3,1,3 and each `req_ready` pulses every other cycle.
- Requester 2 granted, `out_ready` held low for 5 cycles while requester 0 also raises valid:
  - `grant_id` stays 2 and `packet_out` is stable for all 5 cycles.
  - The first accepted beat is requester 2's.
- Requester 1 in BURST drops valid after 2 beats while requester 3 is valid:
  - Same cycle: `grant_id`=3, `out_valid`=1, no bubble.
  - `beat_cnt` restarts at 1.
- `N_REQ`=3 (non-power-of-two), all valid: grant order 0,1,2,0 with `MAX_BURST`=1; `rr_ptr` never takes value 3.
- Reset asserted in WAIT with owner=2: next cycle `out_valid` follows the fresh pick from index 0, and `burst_active`=0.
